// File: rtl/common.sv
// Shared I2S definitions: channel slot width, channel encoding and receiver states.
package common;

    localparam int unsigned I2S_BITS = 16;

    typedef enum logic {CH_LEFT = 1'b0, CH_RIGHT = 1'b1} i2s_chan_t;

    typedef enum logic [1:0] {S_IDLE, S_ALIGN, S_RUN} i2s_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit, cleared by reset_n.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/i2s_receiver.sv
// Philips I2S slave receiver: oversamples BCK/LRCK/DATA in the logic clock domain,
// deserialises left/right words and reports framing errors and link activity.
module i2s_receiver
    import common::*;
#(
    parameter int unsigned BITS           = I2S_BITS,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            i2s_bck,
    input  logic            i2s_lrck,
    input  logic            i2s_data,
    output logic [BITS-1:0] left_data,
    output logic [BITS-1:0] right_data,
    output logic            sample_valid,
    output logic            frame_err,
    output logic            active
);

    localparam int unsigned CW = $clog2(BITS + 2);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    logic bck_s, lrck_s, data_s;

    sync_2ff u_sync_bck  (.clk(clk), .reset_n(reset_n), .d(i2s_bck),  .q(bck_s));
    sync_2ff u_sync_lrck (.clk(clk), .reset_n(reset_n), .d(i2s_lrck), .q(lrck_s));
    sync_2ff u_sync_data (.clk(clk), .reset_n(reset_n), .d(i2s_data), .q(data_s));

    i2s_rx_state_t   state_q,        state_d;
    i2s_chan_t       lrck_q,         lrck_d;
    logic            bck_dly_q,      bck_dly_d;
    // Only BITS-1 history bits are kept; the newest bit comes straight from data_s.
    logic [BITS-2:0] shreg_q,        shreg_d;
    logic [CW-1:0]   bit_cnt_q,      bit_cnt_d;
    logic [TW-1:0]   tmo_cnt_q,      tmo_cnt_d;
    logic [BITS-1:0] left_hold_q,    left_hold_d;
    logic            left_ok_q,      left_ok_d;
    logic [BITS-1:0] left_data_q,    left_data_d;
    logic [BITS-1:0] right_data_q,   right_data_d;
    logic            sample_valid_q, sample_valid_d;
    logic            frame_err_q,    frame_err_d;
    logic            active_q,       active_d;

    logic            rise;
    logic            edge_tr;
    logic            slot_ok;
    logic [BITS-1:0] word;

    always_comb begin
        rise    = bck_s & ~bck_dly_q;
        edge_tr = rise && (lrck_s != lrck_q);
        slot_ok = (bit_cnt_q == CW'(BITS - 1));
        word    = {shreg_q, data_s};

        state_d        = state_q;
        lrck_d         = lrck_q;
        bck_dly_d      = bck_s;
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        left_hold_d    = left_hold_q;
        left_ok_d      = left_ok_q;
        left_data_d    = left_data_q;
        right_data_d   = right_data_q;
        sample_valid_d = 1'b0;
        frame_err_d    = 1'b0;
        active_d       = active_q;

        if (rise) begin
            tmo_cnt_d = '0;
            shreg_d   = word[BITS-2:0];
            lrck_d    = i2s_chan_t'(lrck_s);
            if (edge_tr) begin
                bit_cnt_d = '0;
            end else if (bit_cnt_q != CW'(BITS + 1)) begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end

            // The bit sampled on a transition edge completes the word of channel lrck_q.
            case (state_q)
                S_IDLE: state_d = S_ALIGN;
                S_ALIGN: begin
                    if (edge_tr) begin
                        state_d   = S_RUN;
                        left_ok_d = 1'b0;
                    end
                end
                S_RUN: begin
                    if (edge_tr) begin
                        if (!slot_ok) begin
                            left_ok_d   = 1'b0;
                            frame_err_d = 1'b1;
                        end else if (lrck_q == CH_LEFT) begin
                            left_hold_d = word;
                            left_ok_d   = 1'b1;
                        end else if (left_ok_q) begin
                            left_data_d    = left_hold_q;
                            right_data_d   = word;
                            sample_valid_d = 1'b1;
                            active_d       = 1'b1;
                            left_ok_d      = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end else if (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_IDLE;
            active_d  = 1'b0;
            left_ok_d = 1'b0;
            bit_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            lrck_q         <= CH_LEFT;
            bck_dly_q      <= '0;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            tmo_cnt_q      <= '0;
            left_hold_q    <= '0;
            left_ok_q      <= '0;
            left_data_q    <= '0;
            right_data_q   <= '0;
            sample_valid_q <= '0;
            frame_err_q    <= '0;
            active_q       <= '0;
        end else begin
            state_q        <= state_d;
            lrck_q         <= lrck_d;
            bck_dly_q      <= bck_dly_d;
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            left_hold_q    <= left_hold_d;
            left_ok_q      <= left_ok_d;
            left_data_q    <= left_data_d;
            right_data_q   <= right_data_d;
            sample_valid_q <= sample_valid_d;
            frame_err_q    <= frame_err_d;
            active_q       <= active_d;
        end
    end

    assign left_data    = left_data_q;
    assign right_data   = right_data_q;
    assign sample_valid = sample_valid_q;
    assign frame_err    = frame_err_q;
    assign active       = active_q;

endmodule

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: slot-level reference model predicts the output pairs and
// framing errors of each I2S burst; a monitor compares the DUT on every clock.
`timescale 1ns/100ps
module tb_i2s_receiver;
    import common::*;

    localparam int unsigned BITS = I2S_BITS;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            i2s_bck = 1'b0;
    logic            i2s_lrck = 1'b0;
    logic            i2s_data = 1'b0;
    logic [BITS-1:0] left_data, right_data;
    logic            sample_valid, frame_err, active;

    i2s_receiver #(.BITS(BITS), .TIMEOUT_CYCLES(256)) dut (
        .clk(clk), .reset_n(reset_n), .i2s_bck(i2s_bck), .i2s_lrck(i2s_lrck),
        .i2s_data(i2s_data), .left_data(left_data), .right_data(right_data),
        .sample_valid(sample_valid), .frame_err(frame_err), .active(active)
    );

    always #20 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Slot table of the burst currently being built / played.
    int              sl_chan[$];
    logic [BITS-1:0] sl_word[$];
    int              sl_len[$];

    logic [2*BITS-1:0] exp_q[$];
    int                exp_err = 0;
    int                err_seen = 0;
    int                pulses = 0;
    logic [BITS-1:0]   cur_left = '0, cur_right = '0;
    logic              arm_first = 1'b1, prev_active = 1'b0, prev_sv = 1'b0, mon_en = 1'b0;
    logic [2*BITS-1:0] mon_p;
    int                clks_since = 0;

    task automatic clear_slots();
        sl_chan.delete(); sl_word.delete(); sl_len.delete();
    endtask

    task automatic add_slot(input int ch, input logic [BITS-1:0] w, input int len);
        sl_chan.push_back(ch); sl_word.push_back(w); sl_len.push_back(len);
    endtask

    // A slot ends at the first bit of the next slot; the first slot to end after
    // a (re)start is discarded, a full left followed by a full right forms a pair.
    task automatic model_burst(input int rst_slot);
        logic aligned, lok;
        logic [BITS-1:0] hold;
        aligned = 1'b0; lok = 1'b0; hold = '0;
        for (int i = 0; i < sl_chan.size() - 1; i++) begin
            if (i == 0 || i == rst_slot) begin aligned = 1'b0; lok = 1'b0; end
            if (!aligned) aligned = 1'b1;
            else if (sl_len[i] != BITS) begin exp_err++; lok = 1'b0; end
            else if (sl_chan[i] == 0) begin hold = sl_word[i]; lok = 1'b1; end
            else if (lok) begin exp_q.push_back({hold, sl_word[i]}); lok = 1'b0; end
        end
    endtask

    task automatic play_burst(input realtime h, input int rst_bit);
        logic lr[$];
        logic sb[$];
        for (int i = 0; i < sl_chan.size(); i++) begin
            for (int b = 0; b < sl_len[i]; b++) begin
                lr.push_back(sl_chan[i] != 0);
                sb.push_back(sl_word[i][sl_len[i]-1-b]);
            end
        end
        for (int t = 0; t < lr.size(); t++) begin
            i2s_bck  = 1'b0;
            i2s_lrck = lr[t];
            i2s_data = (t == 0) ? 1'b0 : sb[t-1];
            if (t == rst_bit) begin
                #50;
                cur_left = '0; cur_right = '0;
                reset_n = 1'b0;
                #1;
                check("reset_left_async", left_data, 0);
                check("reset_right_async", right_data, 0);
                check("reset_active_async", active, 0);
                arm_first = 1'b1;
                #199;
                reset_n = 1'b1;
                #(h - 250.0);
            end else begin
                #(h);
            end
            i2s_bck = 1'b1;
            #(h);
        end
        i2s_bck = 1'b0;
    endtask

    task automatic idle_gap();
        repeat (320) @(negedge clk);
        #7.25;
    endtask

    task automatic end_checks(input string tag);
        repeat (10) @(negedge clk);
        check({tag, "_pairs_drained"}, exp_q.size(), 0);
        check({tag, "_frame_err_count"}, err_seen, exp_err);
    endtask

    always @(posedge i2s_bck) clks_since = 0;
    always @(posedge clk) clks_since++;

    always @(negedge clk) begin
        if (mon_en) begin
            check("valid_err_exclusive", sample_valid & frame_err, 0);
            if (sample_valid) begin
                pulses++;
                check("valid_width", prev_sv, 0);
                check("active_with_valid", active, 1);
                if (arm_first) begin
                    check("active_low_before_first_valid", prev_active, 0);
                    arm_first = 1'b0;
                end
                check("valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_p = exp_q.pop_front();
                    cur_left  = mon_p[2*BITS-1:BITS];
                    cur_right = mon_p[BITS-1:0];
                end
            end
            if (frame_err) err_seen++;
            check("left_data", left_data, cur_left);
            check("right_data", right_data, cur_right);
            prev_sv = sample_valid;
            prev_active = active;
        end
    end

    initial begin
        #4ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int p0, e0, waited, pos;
        logic [BITS-1:0] wl, wr;

        #30;
        check("reset_left", left_data, 0);
        check("reset_right", right_data, 0);
        check("reset_valid", sample_valid, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_active", active, 0);
        #70 reset_n = 1'b1;
        mon_en = 1'b1;

        // 44.1 kHz, known pairs after a partial right slot
        idle_gap();
        clear_slots();
        add_slot(1, BITS'($urandom), 9);
        add_slot(0, 16'hA5C3, BITS); add_slot(1, 16'h5A3C, BITS);
        add_slot(0, 16'h0001, BITS); add_slot(1, 16'h8000, BITS);
        add_slot(0, 16'h0000, 4);
        model_burst(-1);
        check("model_pairs_s1", exp_q.size(), 2);
        check("model_pair0_s1", exp_q[0], 32'hA5C35A3C);
        check("model_pair1_s1", exp_q[1], 32'h00018000);
        p0 = pulses;
        play_burst(353.5, -1);
        end_checks("s1");
        check("s1_pulse_count", pulses - p0, 2);
        check("s1_left_final", left_data, 16'h0001);
        check("s1_right_final", right_data, 16'h8000);
        check("s1_active", active, 1);

        // BCK stops: idle after 256 clk from the registered rise
        waited = 0;
        while (active && waited < 400) begin
            @(negedge clk);
            waited++;
        end
        check("timeout_fired", active, 0);
        check("timeout_latency", clks_since, 259);
        repeat (60) @(negedge clk);
        #7.25;

        // Restart with a full left slot: first pair is the second frame
        clear_slots();
        add_slot(0, 16'hFFFF, BITS); add_slot(1, 16'h7777, BITS);
        add_slot(0, 16'h1234, BITS); add_slot(1, 16'h5678, BITS);
        add_slot(0, 16'h9ABC, BITS); add_slot(1, 16'hDEF0, BITS);
        add_slot(0, 16'h0000, 3);
        arm_first = 1'b1;
        model_burst(-1);
        check("model_pairs_s2", exp_q.size(), 2);
        check("model_pair0_s2", exp_q[0], 32'h12345678);
        play_burst(353.5, -1);
        end_checks("s2");

        // Random pairs at 48 kHz
        idle_gap();
        clear_slots();
        add_slot(1, BITS'($urandom), $urandom_range(1, 15));
        for (int i = 0; i < 64; i++) begin
            add_slot(0, BITS'($urandom), BITS);
            add_slot(1, BITS'($urandom), BITS);
        end
        add_slot(0, '0, 4);
        e0 = exp_err;
        arm_first = 1'b1;
        model_burst(-1);
        check("model_pairs_rand", exp_q.size(), 64);
        play_burst(325.5, -1);
        end_checks("rand");
        check("rand_no_frame_err", exp_err - e0, 0);

        // One short right slot mid-stream
        idle_gap();
        clear_slots();
        add_slot(1, BITS'($urandom), 6);
        for (int i = 0; i < 12; i++) begin
            add_slot(0, BITS'($urandom), BITS);
            add_slot(1, BITS'($urandom), (i == 5) ? BITS - 1 : BITS);
        end
        add_slot(0, '0, 4);
        e0 = err_seen;
        arm_first = 1'b1;
        model_burst(-1);
        check("model_pairs_short", exp_q.size(), 11);
        play_burst(353.5, -1);
        end_checks("short");
        check("short_one_frame_err", err_seen - e0, 1);

        // Reset in the middle of a left slot
        idle_gap();
        clear_slots();
        add_slot(1, 16'h1111, 5);
        add_slot(0, 16'h2222, BITS); add_slot(1, 16'h3333, BITS);
        add_slot(0, 16'h4444, BITS); add_slot(1, 16'h5555, BITS);
        add_slot(0, 16'h6666, BITS); add_slot(1, 16'h7777, BITS);
        add_slot(0, 16'h3C3C, BITS); add_slot(1, 16'hC3C3, BITS);
        add_slot(0, '0, 4);
        pos = 0;
        for (int i = 0; i < 3; i++) pos += sl_len[i];
        arm_first = 1'b1;
        model_burst(3);
        check("model_pairs_rst", exp_q.size(), 3);
        check("model_pair1_rst", exp_q[1], 32'h66667777);
        play_burst(353.5, pos + 8);
        end_checks("rst");
        check("rst_left_final", left_data, 16'h3C3C);
        check("rst_right_final", right_data, 16'hC3C3);

        // Stream begins with a complete right slot
        idle_gap();
        clear_slots();
        add_slot(1, 16'hDEAD, BITS);
        add_slot(0, 16'hBEEF, BITS); add_slot(1, 16'hCAFE, BITS);
        add_slot(0, 16'h0F0F, BITS); add_slot(1, 16'hF0F0, BITS);
        add_slot(0, '0, 4);
        arm_first = 1'b1;
        model_burst(-1);
        check("model_pair0_rfirst", exp_q[0], 32'hBEEFCAFE);
        p0 = pulses;
        play_burst(353.5, -1);
        end_checks("rfirst");
        check("rfirst_pulse_count", pulses - p0, 2);
        wl = left_data; wr = right_data;
        check("rfirst_final_pair", {wl, wr}, 32'h0F0FF0F0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
